// File: rtl/imem_boot_if.sv
// Handshake and memory-side signal bundle for the instruction-memory boot sequencer.
// The host (master) streams words and controls the load; the controller (slave) drives the memory and core controls.
interface imem_boot_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W:0]   len;
    logic [31:0]       run_limit;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst_n;
    logic              core_run;
    logic              busy;
    logic              halted;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, len, run_limit, s_valid, s_data,
        input  s_ready, imem_we, imem_waddr, imem_wdata, core_rst_n,
               core_run, busy, halted, err, words_loaded
    );

    modport slave (
        input  start, len, run_limit, s_valid, s_data,
        output s_ready, imem_we, imem_waddr, imem_wdata, core_rst_n,
               core_run, busy, halted, err, words_loaded
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams instruction words into imem, holds the core in reset,
// then runs it for a programmable number of enabled cycles.
module imem_boot_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RST_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    imem_boot_if.slave  bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [ADDR_W:0]   r_len;
    logic [31:0]       r_limit;
    logic [ADDR_W:0]   r_words;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [31:0]       r_run_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_core_rst_n;
    logic              r_core_run;
    logic              r_busy;
    logic              r_halted;
    logic              r_err;

    logic              w_start_ok;
    logic              w_len_bad;
    logic              w_ready;
    logic              w_xfer;
    logic [ADDR_W:0]   w_words_inc;
    logic [31:0]       w_run_inc;

    assign w_start_ok  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_len_bad   = (bus.len > DEPTH);
    assign w_ready     = (r_state == ST_LOAD) && (r_words < r_len);
    assign w_xfer      = w_ready && bus.s_valid;
    assign w_words_inc = r_words + 1'b1;
    assign w_run_inc   = r_run_cnt + 32'd1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (w_start_ok) begin
                    if (w_len_bad)
                        w_state_next = ST_IDLE;
                    else if (bus.len == '0)
                        w_state_next = ST_HOLD;
                    else
                        w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && (w_words_inc == r_len))
                    w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                // Budget counts completed enabled cycles, so HALT follows exactly run_limit RUN cycles.
                if ((r_limit != 32'd0) && (w_run_inc == r_limit))
                    w_state_next = ST_HALT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_limit      <= '0;
            r_words      <= '0;
            r_hold_cnt   <= '0;
            r_run_cnt    <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b0;
            r_core_run   <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            // Status outputs decode the next state so they line up with the state register.
            r_busy       <= (w_state_next == ST_LOAD) || (w_state_next == ST_HOLD) ||
                            (w_state_next == ST_RUN);
            r_core_rst_n <= (w_state_next == ST_RUN) || (w_state_next == ST_HALT);
            r_core_run   <= (w_state_next == ST_RUN);
            r_halted     <= (w_state_next == ST_HALT);
            r_we         <= w_xfer;

            if (w_xfer) begin
                r_waddr <= r_words[ADDR_W-1:0];
                r_wdata <= bus.s_data;
                r_words <= w_words_inc;
            end

            if (w_start_ok) begin
                r_len      <= bus.len;
                r_limit    <= bus.run_limit;
                r_words    <= '0;
                r_err      <= w_len_bad;
                r_hold_cnt <= '0;
                r_run_cnt  <= '0;
            end

            if (r_state == ST_HOLD)
                r_hold_cnt <= r_hold_cnt + 1'b1;
            if (r_state == ST_RUN)
                r_run_cnt <= w_run_inc;
        end
    end

    assign bus.s_ready      = w_ready;
    assign bus.imem_we      = r_we;
    assign bus.imem_waddr   = r_waddr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.core_rst_n   = r_core_rst_n;
    assign bus.core_run     = r_core_run;
    assign bus.busy         = r_busy;
    assign bus.halted       = r_halted;
    assign bus.err          = r_err;
    assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: a write scoreboard plus timing checks on the
// hold/run/halt sequence, error handling, restart and reset behaviour.
module tb_imem_boot_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_boot_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int ln, input logic [31:0] lim);
        bus.start     = 1'b1;
        bus.len       = (AW+1)'(ln);
        bus.run_limit = lim;
        tick();
        bus.start     = 1'b0;
    endtask

    // Drive one word that must be accepted at the next edge; its write shows up one cycle later.
    task automatic send(input logic [DW-1:0] d, input int idx);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        chk("s_ready_before_xfer", 64'(bus.s_ready), 64'd1);
        exp_q.push_back({AW'(idx), d});
        tick();
        bus.s_valid = 1'b0;
        chk("imem_we_after_xfer", 64'(bus.imem_we), 64'd1);
    endtask

    task automatic wait_halted(input int budget, input string tag);
        int n = 0;
        while (bus.halted !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.halted), 64'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 64'({bus.s_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.core_rst_n,
                      bus.core_run, bus.busy, bus.halted, bus.err, bus.words_loaded}), 64'd0);
    endtask

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            logic [AW+DW-1:0] e;
            n_writes++;
            $display("write addr=%0h data=%08h", bus.imem_waddr, bus.imem_wdata);
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(bus.imem_waddr), 64'(e[AW+DW-1:DW]));
                chk("write_data", 64'(bus.imem_wdata), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] prog [4];
        int n;
        int w0;
        prog[0] = 32'h00500093;
        prog[1] = 32'h00300113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;

        bus.start = 1'b0; bus.len = '0; bus.run_limit = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_reset("reset_outputs");
        rst = 1'b0;

        // Nominal load of four words, then 20 enabled cycles.
        do_start(4, 32'd20);
        chk("t1_core_rst_low", 64'(bus.core_rst_n), 64'd0);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 4; i++) send(prog[i], i);
        chk("t1_ready_drop", 64'(bus.s_ready), 64'd0);
        chk("t1_words_loaded", 64'(bus.words_loaded), 64'd4);
        chk("t1_hold_c1", 64'(bus.core_rst_n), 64'd0);
        tick();
        chk("t1_hold_c2", 64'(bus.core_rst_n), 64'd0);
        tick();
        chk("t1_rst_release", 64'(bus.core_rst_n), 64'd1);
        n = 0;
        while (bus.core_run === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("t1_run_cycles", 64'(n), 64'd20);
        chk("t1_halted", 64'(bus.halted), 64'd1);
        chk("t1_halt_core_rst_n", 64'(bus.core_rst_n), 64'd1);
        chk("t1_halt_busy", 64'(bus.busy), 64'd0);

        // Bubbles on s_valid (1,0,0,1,1) with a start pulse that must be ignored mid-load.
        w0 = n_writes;
        do_start(3, 32'd5);
        chk("t2_halted_clr", 64'(bus.halted), 64'd0);
        chk("t2_core_rst_low", 64'(bus.core_rst_n), 64'd0);
        send(32'hA0000001, 0);
        chk("t2_bubble_ready", 64'(bus.s_ready), 64'd1);
        tick();
        chk("t2_bubble_no_we", 64'(bus.imem_we), 64'd0);
        bus.start = 1'b1; bus.len = 9'd7;
        tick();
        bus.start = 1'b0;
        chk("t2_start_ignored", 64'(bus.words_loaded), 64'd1);
        send(32'hA0000002, 1);
        send(32'hA0000003, 2);
        chk("t2_ready_drop", 64'(bus.s_ready), 64'd0);
        chk("t2_words_loaded", 64'(bus.words_loaded), 64'd3);
        wait_halted(50, "t2_halted");
        chk("t2_write_count", 64'(n_writes - w0), 64'd3);

        // Zero-length load: straight to HOLD, no writes.
        w0 = n_writes;
        do_start(0, 32'd3);
        chk("t3_busy", 64'(bus.busy), 64'd1);
        chk("t3_no_ready", 64'(bus.s_ready), 64'd0);
        tick();
        chk("t3_hold_c2", 64'(bus.core_rst_n), 64'd0);
        tick();
        chk("t3_rst_release", 64'(bus.core_rst_n), 64'd1);
        wait_halted(20, "t3_halted");
        chk("t3_no_writes", 64'(n_writes - w0), 64'd0);

        // Oversized length: error, back to IDLE, core held in reset.
        do_start(257, 32'd5);
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_busy", 64'(bus.busy), 64'd0);
        chk("t4_core_rst_n", 64'(bus.core_rst_n), 64'd0);
        chk("t4_halted", 64'(bus.halted), 64'd0);
        repeat (3) tick();
        chk("t4_core_rst_stays", 64'(bus.core_rst_n), 64'd0);
        chk("t4_err_sticky", 64'(bus.err), 64'd1);

        // Full-depth load ends at the top address.
        do_start(256, 32'd1);
        chk("t5_err_clr", 64'(bus.err), 64'd0);
        for (int i = 0; i < 256; i++) send($urandom, i);
        chk("t5_last_waddr", 64'(bus.imem_waddr), 64'hFF);
        chk("t5_words_loaded", 64'(bus.words_loaded), 64'd256);
        wait_halted(20, "t5_halted");

        // Reset after two of five words, then a clean reload from address 0.
        do_start(5, 32'd0);
        send(32'hB0000000, 0);
        send(32'hB0000001, 1);
        rst = 1'b1;
        tick();
        chk_reset("t6_reset_outputs");
        chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        do_start(5, 32'd4);
        for (int i = 0; i < 5; i++) send(32'hC0000000 + 32'(i), i);
        wait_halted(30, "t6_halted");

        // Restart from HALT with an unlimited budget; start during RUN is ignored.
        do_start(1, 32'd0);
        chk("t7_core_rst_low", 64'(bus.core_rst_n), 64'd0);
        chk("t7_halted_clr", 64'(bus.halted), 64'd0);
        send(32'h0000006F, 0);
        tick();
        tick();
        chk("t7_run", 64'(bus.core_run), 64'd1);
        bus.start = 1'b1; bus.len = 9'd3; bus.run_limit = 32'd2;
        tick();
        bus.start = 1'b0;
        chk("t7_start_ignored", 64'(bus.words_loaded), 64'd1);
        n = 0;
        repeat (50) begin
            if (bus.core_run === 1'b1) n++;
            tick();
        end
        chk("t7_run_forever", 64'(n), 64'd50);
        chk("t7_not_halted", 64'(bus.halted), 64'd0);

        tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot sequencer for the single-cycle RISC-V core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the instruction memory write port at sequential word addresses. It holds the core in reset while loading, releases it after a fixed hold, then gates execution with a run enable. Execution stops after a programmable cycle budget, which replaces bench-side preloading of instruction memory and fixed cycle counts.

Parameters:
ADDR_W, 8, instruction memory word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width
RST_HOLD, 2, cycles core_rst_n stays low after the last word is written (must be ≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a load of len words
len  in  ADDR_W+1  number of words to load, sampled on accepted start
run_limit  in  32  core cycle budget, sampled on accepted start; 0 = unlimited
s_valid  in  1  instruction word valid
s_data  in  DATA_W  instruction word
s_ready  out  1  controller can accept a word
imem_we  out  1  instruction memory write enable
imem_waddr  out  ADDR_W  instruction memory word address
imem_wdata  out  DATA_W  instruction memory write data
core_rst_n  out  1  active-low reset to the core
core_run  out  1  core execution enable (stall when 0)
busy  out  1  state is LOAD, HOLD or RUN
halted  out  1  run budget exhausted
err  out  1  sticky; len exceeded depth on the last start
words_loaded  out  ADDR_W+1  count of words written in the current load

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, HALT. State advances on the rising edge of clk.
- Reset (rst=1 at a clk edge, from any state, including mid-load or mid-run):
  - state=IDLE.
  - Outputs: s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, core_run=0, busy=0, halted=0, err=0, words_loaded=0.
  - All internal counters are cleared.
- Start acceptance: start is accepted only in IDLE or HALT. A start in any other state is ignored.
- On an accepted start:
  - Latch len and run_limit. Clear words_loaded, halted and err.
  - core_rst_n=0 and core_run=0 from the next cycle.
  - If len > 2**ADDR_W: set err=1 and go to IDLE.
  - Else if len == 0: go to HOLD.
  - Else: go to LOAD.
- LOAD:
  - s_ready=1 while words_loaded < len (combinational from state and count).
  - A word transfers when s_valid and s_ready are both high at a clk edge.
  - Write latency is 1 cycle. The cycle after a transfer, imem_we=1, imem_waddr = index of that word (0, 1, 2, …), imem_wdata = s_data of that word. Otherwise imem_we=0.
  - words_loaded increments on the transfer edge.
  - When the transfer that makes words_loaded == len occurs: go to HOLD, and s_ready drops to 0 in the same edge.
  - s_valid=0 cycles insert bubbles; there is no timeout.
- HOLD:
  - core_rst_n=0. A counter runs RST_HOLD cycles.
  - The final imem write, issued in the first HOLD cycle, completes while the core is still in reset.
  - Then go to RUN.
- RUN:
  - core_rst_n=1 and core_run=1. A 32-bit cycle counter starts at 0 and increments each RUN cycle.
  - If run_limit != 0 and the counter reaches run_limit: go to HALT. The core therefore executes exactly run_limit enabled cycles.
  - If run_limit == 0: stay in RUN until rst.
- HALT:
  - core_run=0 and core_rst_n=1, so the register file and PC are preserved for readout. halted=1.
  - An accepted start re-enters load with the core back in reset.
- Simultaneous events: rst wins over everything. start and s_valid in the same IDLE cycle: the word is not accepted (s_ready=0 in IDLE).
- imem_waddr wraps never: len ≤ 2**ADDR_W is guaranteed by the err check, so the last index is 2**ADDR_W-1.
- All outputs except s_ready are registered.

Test Plan:
- Nominal load-and-run: rst 2 cycles; start with len=4, run_limit=20; stream 0x00500093, 0x00300113, 0x002081B3, 0x00000013 with s_valid held high.
  - Required: imem_we on 4 consecutive cycles, addresses 0..3, matching data.
  - Required: core_rst_n rises RST_HOLD=2 cycles after the last write; core_run high exactly 20 cycles; then halted=1.
- Backpressure and bubbles: len=3, s_valid toggling 1,0,0,1,1.
  - Required: exactly 3 writes at addresses 0, 1, 2; s_ready=0 after the third transfer; words_loaded=3.
- Boundaries:
  - len=0: goes straight to HOLD; no imem_we pulses.
  - len=257 with ADDR_W=8: err=1, state IDLE, core_rst_n stays 0.
  - len=256: last write at imem_waddr=0xFF.
- Reset mid-operation: rst asserted after 2 of 5 words loaded → next cycle all outputs at reset values. A subsequent start with len=5 rewrites from address 0.
- Restart and ignore rules: start pulsed during LOAD and during RUN is ignored. From HALT, start with len=1, run_limit=0 → core_rst_n=0 and halted=0 next cycle, reload, then core_run stays 1 indefinitely.
